// File: rtl/riscv_memory_lsu_pkg.sv
// riscv_memory_lsu_pkg: shared encodings for the memory-stage load/store unit.
// Holds the funct3 access codes, the LSU FSM state encoding and the XLEN default.
package riscv_memory_lsu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // log2 of the number of bytes touched by an access with this funct3
    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/riscv_memory_lsu_align.sv
// riscv_memory_lsu_align: combinational lane logic for the LSU.
// Request side: byte enables, store-data lane replication and the misalign/illegal check.
// Response side: load lane select followed by sign or zero extension.
module riscv_memory_lsu_align
    import riscv_memory_lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    localparam int BE_W = XLEN / 8,
    localparam int OFF_W = $clog2(BE_W)
) (
    input  logic             req_store,
    input  logic [2:0]       req_funct3,
    input  logic [OFF_W-1:0] req_offset,
    input  logic [XLEN-1:0]  req_wdata,
    output logic [BE_W-1:0]  req_be,
    output logic [XLEN-1:0]  req_wdata_lanes,
    output logic             req_misalign,
    input  logic [2:0]       rsp_funct3,
    input  logic [OFF_W-1:0] rsp_offset,
    input  logic [XLEN-1:0]  rsp_rdata,
    output logic [XLEN-1:0]  rsp_data
);

    localparam bit WIDE = (XLEN == 64);

    logic [BE_W-1:0] size_mask;
    logic [XLEN-1:0] lane;

    // Flag accesses that are misaligned or not encodable on this datapath width
    always_comb begin
        req_misalign = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: req_misalign = 1'b0;
            F3_H, F3_HU: req_misalign = req_offset[0];
            F3_W:        req_misalign = |req_offset[1:0];
            F3_WU:       req_misalign = !WIDE || (|req_offset[1:0]);
            F3_D:        req_misalign = !WIDE || (|req_offset);
            default:     req_misalign = 1'b1;
        endcase
        if (req_store && req_funct3[2]) begin
            req_misalign = 1'b1;
        end
    end

    // Byte enables: a size mask shifted up to the addressed byte lane
    always_comb begin
        case (access_size(req_funct3))
            2'd0:    size_mask = BE_W'(1);
            2'd1:    size_mask = BE_W'(3);
            2'd2:    size_mask = BE_W'(15);
            default: size_mask = '1;
        endcase
        req_be = size_mask << req_offset;
    end

    // Replicate right-aligned store data into every lane so the enables pick the right one
    always_comb begin
        case (access_size(req_funct3))
            2'd0:    req_wdata_lanes = {BE_W{req_wdata[7:0]}};
            2'd1:    req_wdata_lanes = {(BE_W / 2){req_wdata[15:0]}};
            2'd2:    req_wdata_lanes = {(BE_W / 4){req_wdata[31:0]}};
            default: req_wdata_lanes = req_wdata;
        endcase
    end

    // Shift the addressed lane down to bit 0 and extend according to funct3
    always_comb begin
        lane = rsp_rdata >> {rsp_offset, 3'b000};
        case (rsp_funct3)
            F3_B:    rsp_data = XLEN'($signed(lane[7:0]));
            F3_H:    rsp_data = XLEN'($signed(lane[15:0]));
            F3_W:    rsp_data = XLEN'($signed(lane[31:0]));
            F3_BU:   rsp_data = XLEN'(lane[7:0]);
            F3_HU:   rsp_data = XLEN'(lane[15:0]);
            F3_WU:   rsp_data = XLEN'(lane[31:0]);
            default: rsp_data = lane;
        endcase
    end

endmodule

// File: rtl/riscv_memory_lsu.sv
// riscv_memory_lsu: memory-stage load/store unit driving a req/gnt/rvalid data port.
// Optional one-entry posted store buffer enabled by defining RISCV_LSU_STORE_BUF_EN.
module riscv_memory_lsu
    import riscv_memory_lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int ADDR_W = 16,
    localparam int BE_W = XLEN / 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_valid_m,
    input  logic                             i_mem_read_m,
    input  logic                             i_mem_write_m,
    input  logic [2:0]                       i_funct3_m,
    input  logic [XLEN-1:0]                  i_alu_result_m,
    input  logic [XLEN-1:0]                  i_write_data_m,
    output logic [XLEN-1:0]                  o_read_data_m,
    output logic                             o_done_m,
    output logic                             o_stall_m,
    output logic                             o_misalign_m,
    output logic                             o_dmem_req,
    output logic                             o_dmem_we,
    output logic [ADDR_W-$clog2(BE_W)-1:0]   o_dmem_addr,
    output logic [BE_W-1:0]                  o_dmem_be,
    output logic [XLEN-1:0]                  o_dmem_wdata,
    input  logic                             i_dmem_gnt,
    input  logic                             i_dmem_rvalid,
    input  logic [XLEN-1:0]                  i_dmem_rdata
);

    localparam int OFF_W = $clog2(BE_W);

`ifdef RISCV_LSU_STORE_BUF_EN
    localparam bit STORE_BUF = 1'b1;
`else
    localparam bit STORE_BUF = 1'b0;
`endif

    lsu_state_t state;
    lsu_state_t next_state;

    logic                    access;
    logic                    misalign;
    logic                    accept;
    logic                    post;
    logic [BE_W-1:0]         be;
    logic [XLEN-1:0]         wdata_lanes;
    logic [XLEN-1:0]         load_data;
    logic [2:0]              funct3_q;
    logic [OFF_W-1:0]        offset_q;
    logic                    we_q;
    logic                    posted_q;
    logic                    post_done_q;
    logic                    misalign_q;
    logic [ADDR_W-OFF_W-1:0] addr_q;
    logic [BE_W-1:0]         be_q;
    logic [XLEN-1:0]         wdata_q;
    logic [XLEN-1:0]         read_data_q;
    logic                    unused_addr_bits;

    assign access           = i_mem_read_m | i_mem_write_m;
    assign accept           = (state == IDLE) && i_valid_m && access && !misalign;
    assign post             = accept && i_mem_write_m && STORE_BUF;
    assign unused_addr_bits = ^i_alu_result_m[XLEN-1:ADDR_W];

    riscv_memory_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .req_store       (i_mem_write_m),
        .req_funct3      (i_funct3_m),
        .req_offset      (i_alu_result_m[OFF_W-1:0]),
        .req_wdata       (i_write_data_m),
        .req_be          (be),
        .req_wdata_lanes (wdata_lanes),
        .req_misalign    (misalign),
        .rsp_funct3      (funct3_q),
        .rsp_offset      (offset_q),
        .rsp_rdata       (i_dmem_rdata),
        .rsp_data        (load_data)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: posted stores return to IDLE on grant, everything else finishes in DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (i_dmem_gnt) begin
                    if (posted_q) begin
                        next_state = IDLE;
                    end else if (we_q || i_dmem_rvalid) begin
                        next_state = DONE;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (i_dmem_rvalid) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Latch the request fields on acceptance so they stay stable while req is up
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            offset_q    <= '0;
            posted_q    <= 1'b0;
            post_done_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= i_alu_result_m[ADDR_W-1:OFF_W];
                be_q     <= be;
                wdata_q  <= wdata_lanes;
                we_q     <= i_mem_write_m;
                funct3_q <= i_funct3_m;
                offset_q <= i_alu_result_m[OFF_W-1:0];
                posted_q <= post;
            end else if ((state == REQ) && i_dmem_gnt) begin
                posted_q <= 1'b0;
            end
            post_done_q <= post;
            misalign_q  <= (state == IDLE) && i_valid_m && access && misalign;
        end
    end

    // Capture extended load data when it returns, either with the grant or later in WAIT
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            read_data_q <= '0;
        end else if (i_dmem_rvalid && !we_q &&
                     (((state == REQ) && i_dmem_gnt) || (state == WAIT))) begin
            read_data_q <= load_data;
        end
    end

    // Outputs decoded from state and the request registers
    always_comb begin
        o_dmem_req   = (state == REQ);
        o_dmem_we    = we_q;
        o_dmem_addr  = addr_q;
        o_dmem_be    = be_q;
        o_dmem_wdata = wdata_q;
        o_read_data_m = read_data_q;
        o_misalign_m = misalign_q;
        o_done_m     = (state == DONE) || post_done_q;
        o_stall_m    = (accept && !post) ||
                       ((state == REQ) && (!posted_q || (i_valid_m && access))) ||
                       (state == WAIT);
    end

endmodule

// File: tb/tb_riscv_memory_lsu.sv
// tb_riscv_memory_lsu: directed and randomized bench for riscv_memory_lsu (XLEN=32, ADDR_W=16).
// Expected results come from arithmetic models of the access rules; the bench also plays memory.
module tb_riscv_memory_lsu;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 16;
    localparam int BE_W   = 4;

`ifdef RISCV_LSU_STORE_BUF_EN
    localparam bit BUF_MODE = 1'b1;
`else
    localparam bit BUF_MODE = 1'b0;
`endif

    logic              i_clk;
    logic              i_rst;
    logic              i_valid_m;
    logic              i_mem_read_m;
    logic              i_mem_write_m;
    logic [2:0]        i_funct3_m;
    logic [XLEN-1:0]   i_alu_result_m;
    logic [XLEN-1:0]   i_write_data_m;
    logic [XLEN-1:0]   o_read_data_m;
    logic              o_done_m;
    logic              o_stall_m;
    logic              o_misalign_m;
    logic              o_dmem_req;
    logic              o_dmem_we;
    logic [ADDR_W-3:0] o_dmem_addr;
    logic [BE_W-1:0]   o_dmem_be;
    logic [XLEN-1:0]   o_dmem_wdata;
    logic              i_dmem_gnt;
    logic              i_dmem_rvalid;
    logic [XLEN-1:0]   i_dmem_rdata;

    int checks = 0;
    int fails  = 0;

    riscv_memory_lsu #(
        .XLEN(XLEN),
        .ADDR_W(ADDR_W)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid_m      (i_valid_m),
        .i_mem_read_m   (i_mem_read_m),
        .i_mem_write_m  (i_mem_write_m),
        .i_funct3_m     (i_funct3_m),
        .i_alu_result_m (i_alu_result_m),
        .i_write_data_m (i_write_data_m),
        .o_read_data_m  (o_read_data_m),
        .o_done_m       (o_done_m),
        .o_stall_m      (o_stall_m),
        .o_misalign_m   (o_misalign_m),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_be      (o_dmem_be),
        .o_dmem_wdata   (o_dmem_wdata),
        .i_dmem_gnt     (i_dmem_gnt),
        .i_dmem_rvalid  (i_dmem_rvalid),
        .i_dmem_rdata   (i_dmem_rdata)
    );

    // Free-running clock, period 10
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic applyStimulus(input bit valid, input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data);
        i_valid_m      = valid;
        i_mem_read_m   = rd;
        i_mem_write_m  = wr;
        i_funct3_m     = f3;
        i_alu_result_m = addr;
        i_write_data_m = data;
    endtask

    function automatic int bytesOf(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit modelIllegal(input bit isLoad, input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = bytesOf(f3);
        if (f3 == 3'b111) return 1'b1;
        if (!isLoad && f3[2]) return 1'b1;
        if (n > XLEN / 8) return 1'b1;
        if (f3 == 3'b110 && XLEN == 32) return 1'b1;
        return (int'(addr[3:0]) % n) != 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        int off;
        n   = bytesOf(f3);
        off = int'(addr[1:0]);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] r;
        int n;
        n = bytesOf(f3);
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = data[8*(i % n) +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        longint v;
        longint span;
        int n;
        int off;
        n    = bytesOf(f3);
        off  = int'(addr[1:0]);
        span = longint'(1) << (8 * n);
        v    = longint'(rdata >> (8 * off)) % span;
        if (!f3[2] && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // One complete access: drive it, act as memory with the given delays, check against the model
    task automatic runAccess(input bit isLoad, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input int gntDelay, input int rvDelay,
                             input logic [31:0] rdata, input bit dropValid);
        bit posted;
        bit granted;
        bit rvSent;
        bit finished;
        int reqCycles;
        int gntCyc;
        int doneCyc;
        int doneCount;
        int stallCnt;
        int expDone;
        posted    = BUF_MODE && !isLoad;
        granted   = 1'b0;
        rvSent    = 1'b0;
        finished  = 1'b0;
        reqCycles = 0;
        gntCyc    = 0;
        doneCyc   = -1;
        doneCount = 0;
        stallCnt  = 0;
        applyStimulus(1'b1, isLoad, !isLoad, f3, addr, data);
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b0;
        if (modelIllegal(isLoad, f3, addr)) begin
            #1;
            checkOutput("misal_stall", o_stall_m, 0);
            stepCycle();
            i_valid_m = 1'b0;
            #1;
            checkOutput("misal_pulse", o_misalign_m, 1);
            checkOutput("misal_noreq", o_dmem_req, 0);
            checkOutput("misal_nodone", o_done_m, 0);
            stepCycle();
            #1;
            checkOutput("misal_once", o_misalign_m, 0);
            checkOutput("misal_noreq2", o_dmem_req, 0);
            return;
        end
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            if (cyc == 1 && (posted || dropValid)) i_valid_m = 1'b0;
            i_dmem_gnt    = 1'b0;
            i_dmem_rvalid = 1'b0;
            i_dmem_rdata  = $urandom();
            if (o_dmem_req) begin
                checkOutput("req_we", o_dmem_we, !isLoad);
                checkOutput("req_addr", o_dmem_addr, 64'(addr[15:2]));
                checkOutput("req_be", o_dmem_be, modelBe(f3, addr));
                if (!isLoad) checkOutput("req_wdata", o_dmem_wdata, modelWdata(f3, data));
                if (reqCycles == gntDelay) begin
                    i_dmem_gnt = 1'b1;
                    granted    = 1'b1;
                    gntCyc     = cyc;
                    if (isLoad && rvDelay == 0) begin
                        i_dmem_rvalid = 1'b1;
                        i_dmem_rdata  = rdata;
                        rvSent        = 1'b1;
                    end
                end
                reqCycles++;
            end else if (granted && isLoad && !rvSent && (cyc - gntCyc) == rvDelay) begin
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata  = rdata;
                rvSent        = 1'b1;
            end
            #1;
            if (o_stall_m) stallCnt++;
            if (o_done_m) begin
                doneCount++;
                if (doneCyc < 0) doneCyc = cyc;
                if (isLoad) checkOutput("load_data", o_read_data_m, modelLoad(f3, addr, rdata));
            end
            finished = (doneCyc >= 0) && (!posted || granted);
            if (!finished) stepCycle();
        end
        checkOutput("complete", finished, 1);
        expDone = posted ? 1 : (isLoad ? 2 + gntDelay + rvDelay : 2 + gntDelay);
        checkOutput("done_cycle", doneCyc, expDone);
        checkOutput("stall_cycles", stallCnt, posted ? 0 : expDone);
        checkOutput("req_cycles", reqCycles, gntDelay + 1);
        checkOutput("done_count", doneCount, 1);
        i_valid_m     = 1'b0;
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b0;
        stepCycle();
        #1;
        checkOutput("idle_req", o_dmem_req, 0);
        checkOutput("idle_done", o_done_m, 0);
    endtask

    initial begin
        bit          isLoad;
        logic [2:0]  f3;
        logic [31:0] addr;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = '0;
        i_rst         = 1'b1;
        @(negedge i_clk);
        stepCycle();
        i_rst = 1'b0;
        #1;
        $display("[TB] reset values");
        checkOutput("rst_req", o_dmem_req, 0);
        checkOutput("rst_we", o_dmem_we, 0);
        checkOutput("rst_addr", o_dmem_addr, 0);
        checkOutput("rst_be", o_dmem_be, 0);
        checkOutput("rst_wdata", o_dmem_wdata, 0);
        checkOutput("rst_rdata", o_read_data_m, 0);
        checkOutput("rst_done", o_done_m, 0);
        checkOutput("rst_misal", o_misalign_m, 0);
        checkOutput("rst_stall", o_stall_m, 0);

        $display("[TB] directed accesses");
        runAccess(1'b0, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0);
        runAccess(1'b1, 3'b000, 32'h0000_0013, 32'h0, 0, 2, 32'h80FF_FF00, 1'b0);
        runAccess(1'b1, 3'b100, 32'h0000_0013, 32'h0, 0, 2, 32'h80FF_FF00, 1'b0);
        runAccess(1'b1, 3'b001, 32'h0000_0001, 32'h0, 0, 0, 32'h0, 1'b0);
        runAccess(1'b0, 3'b010, 32'h0000_0020, 32'h1234_5678, 5, 0, 32'h0, 1'b0);
        runAccess(1'b1, 3'b101, 32'h0000_0026, 32'h0, 5, 0, 32'h9ABC_1234, 1'b1);
        runAccess(1'b1, 3'b110, 32'h0000_0028, 32'h0, 0, 0, 32'h0, 1'b0);

        $display("[TB] stray handshakes in idle");
        i_dmem_gnt    = 1'b1;
        i_dmem_rvalid = 1'b1;
        stepCycle();
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b0;
        #1;
        checkOutput("stray_done", o_done_m, 0);
        checkOutput("stray_req", o_dmem_req, 0);

        $display("[TB] reset while waiting for read data");
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
        stepCycle();
        i_dmem_gnt = 1'b1;
        #1;
        checkOutput("rstw_req", o_dmem_req, 1);
        stepCycle();
        i_dmem_gnt = 1'b0;
        #1;
        checkOutput("rstw_stall", o_stall_m, 1);
        i_rst     = 1'b1;
        i_valid_m = 1'b0;
        stepCycle();
        i_rst         = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'hCAFE_F00D;
        #1;
        checkOutput("rstw_req_drop", o_dmem_req, 0);
        checkOutput("rstw_stall_drop", o_stall_m, 0);
        checkOutput("rstw_done", o_done_m, 0);
        stepCycle();
        i_dmem_rvalid = 1'b0;
        #1;
        checkOutput("late_rvalid_done", o_done_m, 0);
        checkOutput("late_rvalid_data", o_read_data_m, 0);

`ifdef RISCV_LSU_STORE_BUF_EN
        $display("[TB] posted store followed by load");
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0031, 32'h0000_00A5);
        #1;
        checkOutput("sb_nostall", o_stall_m, 0);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0050, 32'h0);
        #1;
        checkOutput("sb_done", o_done_m, 1);
        checkOutput("sb_req", o_dmem_req, 1);
        checkOutput("sb_be", o_dmem_be, 4'b0010);
        checkOutput("sb_wdata", o_dmem_wdata, 32'hA5A5_A5A5);
        checkOutput("lw_stall1", o_stall_m, 1);
        for (int k = 0; k < 2; k++) begin
            stepCycle();
            #1;
            checkOutput("lw_stall_wait", o_stall_m, 1);
            checkOutput("sb_done_once", o_done_m, 0);
        end
        stepCycle();
        i_dmem_gnt = 1'b1;
        #1;
        checkOutput("sb_gnt_stall", o_stall_m, 1);
        checkOutput("sb_gnt_we", o_dmem_we, 1);
        stepCycle();
        i_dmem_gnt = 1'b0;
        #1;
        checkOutput("lw_accept_req", o_dmem_req, 0);
        checkOutput("lw_accept_stall", o_stall_m, 1);
        stepCycle();
        #1;
        checkOutput("lw_req", o_dmem_req, 1);
        checkOutput("lw_we", o_dmem_we, 0);
        checkOutput("lw_addr", o_dmem_addr, 14'h0014);
        i_dmem_gnt    = 1'b1;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h1122_3344;
        stepCycle();
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_valid_m     = 1'b0;
        #1;
        checkOutput("lw_done", o_done_m, 1);
        checkOutput("lw_data", o_read_data_m, 32'h1122_3344);
        checkOutput("lw_done_stall", o_stall_m, 0);
        stepCycle();
`endif

        $display("[TB] randomized accesses");
        for (int t = 0; t < 60; t++) begin
            isLoad = 1'($urandom_range(0, 1));
            f3     = 3'($urandom_range(0, 7));
            addr   = $urandom();
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            runAccess(isLoad, f3, addr, $urandom(), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), $urandom(), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
